// File: rtl/display_7seg_words.sv
// Four-digit 7-segment word display. It shows blank, PUSH, GOOd or FAIL according to mode.
// Outputs are registered with one clock of latency. There is no handshake, and mode is sampled on every edge.
module display_7seg_words (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] mode,
  output logic [6:0] display_words_3,
  output logic [6:0] display_words_2,
  output logic [6:0] display_words_1,
  output logic [6:0] display_words_0
);

  // Internal character codes. Codes 12..15 are unused and render blank.
  localparam logic [3:0] CH_BLANK = 4'd0;
  localparam logic [3:0] CH_P     = 4'd1;
  localparam logic [3:0] CH_U     = 4'd2;
  localparam logic [3:0] CH_S     = 4'd3;
  localparam logic [3:0] CH_H     = 4'd4;
  localparam logic [3:0] CH_G     = 4'd5;
  localparam logic [3:0] CH_O     = 4'd6;
  localparam logic [3:0] CH_D     = 4'd7;
  localparam logic [3:0] CH_F     = 4'd8;
  localparam logic [3:0] CH_A     = 4'd9;
  localparam logic [3:0] CH_I     = 4'd10;
  localparam logic [3:0] CH_L     = 4'd11;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Segment order is {g,f,e,d,c,b,a}. Segments are active-low for common-anode parts.
  function automatic logic [6:0] char_to_seg(input logic [3:0] code);
    logic [6:0] seg;
    case (code)
      CH_P:    seg = 7'b0001100;
      CH_U:    seg = 7'b1000001;
      CH_S:    seg = 7'b0010010;
      CH_H:    seg = 7'b0001001;
      CH_G:    seg = 7'b1000010;
      CH_O:    seg = 7'b1000000;
      CH_D:    seg = 7'b0100001;
      CH_F:    seg = 7'b0001110;
      CH_A:    seg = 7'b0001000;
      CH_I:    seg = 7'b1111001;
      CH_L:    seg = 7'b1000111;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

  logic [3:0] char3, char2, char1, char0;

  always_comb begin
    char3 = CH_BLANK;
    char2 = CH_BLANK;
    char1 = CH_BLANK;
    char0 = CH_BLANK;
    case (mode)
      2'b01: begin
        char3 = CH_P; char2 = CH_U; char1 = CH_S; char0 = CH_H;
      end
      2'b10: begin
        char3 = CH_G; char2 = CH_O; char1 = CH_O; char0 = CH_D;
      end
      2'b11: begin
        char3 = CH_F; char2 = CH_A; char1 = CH_I; char0 = CH_L;
      end
      default: begin
        char3 = CH_BLANK; char2 = CH_BLANK; char1 = CH_BLANK; char0 = CH_BLANK;
      end
    endcase
  end

  logic [6:0] digit3_d, digit2_d, digit1_d, digit0_d;
  logic [6:0] digit3_q, digit2_q, digit1_q, digit0_q;

  always_comb begin
    digit3_d = char_to_seg(char3);
    digit2_d = char_to_seg(char2);
    digit1_d = char_to_seg(char1);
    digit0_d = char_to_seg(char0);
  end

  // All four digits share one register stage, so a word change is never seen half-applied.
  always_ff @(posedge clk) begin
    if (rst) begin
      digit3_q <= SEG_BLANK;
      digit2_q <= SEG_BLANK;
      digit1_q <= SEG_BLANK;
      digit0_q <= SEG_BLANK;
    end else begin
      digit3_q <= digit3_d;
      digit2_q <= digit2_d;
      digit1_q <= digit1_d;
      digit0_q <= digit0_d;
    end
  end

  assign display_words_3 = digit3_q;
  assign display_words_2 = digit2_q;
  assign display_words_1 = digit1_q;
  assign display_words_0 = digit0_q;

endmodule

// File: tb/tb_display_7seg_words.sv
// Directed bench for display_7seg_words. The four digits are compared as one 28-bit word {d3,d2,d1,d0}.
module tb_display_7seg_words;

  logic       clk;
  logic       rst;
  logic [1:0] mode;
  logic [6:0] display_words_3, display_words_2, display_words_1, display_words_0;
  logic [27:0] obs;

  int vectors;
  int miscompares;

  localparam logic [27:0] W_BLANK = {7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111};
  localparam logic [27:0] W_PUSH  = {7'b0001100, 7'b1000001, 7'b0010010, 7'b0001001};
  localparam logic [27:0] W_GOOD  = {7'b1000010, 7'b1000000, 7'b1000000, 7'b0100001};
  localparam logic [27:0] W_FAIL  = {7'b0001110, 7'b0001000, 7'b1111001, 7'b1000111};

  display_7seg_words dut (
    .clk             (clk),
    .rst             (rst),
    .mode            (mode),
    .display_words_3 (display_words_3),
    .display_words_2 (display_words_2),
    .display_words_1 (display_words_1),
    .display_words_0 (display_words_0)
  );

  assign obs = {display_words_3, display_words_2, display_words_1, display_words_0};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change just after a falling edge. Outputs are read at the next falling edge.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; mode = 2'b11;
    step();
    vectors++;
    if (obs !== W_BLANK) begin
      miscompares++;
      $display("FAIL reset_edge1 got=%b want=%b", obs, W_BLANK);
    end
    step();
    vectors++;
    if (obs !== W_BLANK) begin
      miscompares++;
      $display("FAIL reset_held got=%b want=%b", obs, W_BLANK);
    end
  endtask

  task automatic test_push();
    rst = 1'b0; mode = 2'b01;
    step();
    vectors++;
    if (obs !== W_PUSH) begin
      miscompares++;
      $display("FAIL push_after_release got=%b want=%b", obs, W_PUSH);
    end
    step();
    vectors++;
    if (obs !== W_PUSH) begin
      miscompares++;
      $display("FAIL push_hold got=%b want=%b", obs, W_PUSH);
    end
  endtask

  task automatic test_good();
    mode = 2'b10;
    #1;
    vectors++;
    if (obs !== W_PUSH) begin
      miscompares++;
      $display("FAIL good_before_edge got=%b want=%b", obs, W_PUSH);
    end
    step();
    vectors++;
    if (obs !== W_GOOD) begin
      miscompares++;
      $display("FAIL good got=%b want=%b", obs, W_GOOD);
    end
  endtask

  task automatic test_fail_word();
    mode = 2'b11;
    step();
    vectors++;
    if (obs !== W_FAIL) begin
      miscompares++;
      $display("FAIL fail_word got=%b want=%b", obs, W_FAIL);
    end
  endtask

  task automatic test_back_to_back();
    mode = 2'b00;
    step();
    vectors++;
    if (obs !== W_BLANK) begin
      miscompares++;
      $display("FAIL b2b_blank got=%b want=%b", obs, W_BLANK);
    end
    mode = 2'b01;
    step();
    vectors++;
    if (obs !== W_PUSH) begin
      miscompares++;
      $display("FAIL b2b_push got=%b want=%b", obs, W_PUSH);
    end
    mode = 2'b10;
    step();
    vectors++;
    if (obs !== W_GOOD) begin
      miscompares++;
      $display("FAIL b2b_good got=%b want=%b", obs, W_GOOD);
    end
    mode = 2'b11;
    step();
    vectors++;
    if (obs !== W_FAIL) begin
      miscompares++;
      $display("FAIL b2b_fail got=%b want=%b", obs, W_FAIL);
    end
    mode = 2'b00;
    step();
    vectors++;
    if (obs !== W_BLANK) begin
      miscompares++;
      $display("FAIL b2b_blank_end got=%b want=%b", obs, W_BLANK);
    end
  endtask

  task automatic test_reset_override();
    mode = 2'b01;
    step();
    vectors++;
    if (obs !== W_PUSH) begin
      miscompares++;
      $display("FAIL ovr_push got=%b want=%b", obs, W_PUSH);
    end
    // Reset is raised between edges. The outputs must not move until the next rising edge.
    rst = 1'b1; mode = 2'b11;
    #1;
    vectors++;
    if (obs !== W_PUSH) begin
      miscompares++;
      $display("FAIL ovr_no_async got=%b want=%b", obs, W_PUSH);
    end
    step();
    vectors++;
    if (obs !== W_BLANK) begin
      miscompares++;
      $display("FAIL ovr_rst_wins got=%b want=%b", obs, W_BLANK);
    end
    step();
    vectors++;
    if (obs !== W_BLANK) begin
      miscompares++;
      $display("FAIL ovr_rst_held got=%b want=%b", obs, W_BLANK);
    end
    rst = 1'b0;
    #1;
    vectors++;
    if (obs !== W_BLANK) begin
      miscompares++;
      $display("FAIL ovr_before_release_edge got=%b want=%b", obs, W_BLANK);
    end
    step();
    vectors++;
    if (obs !== W_FAIL) begin
      miscompares++;
      $display("FAIL ovr_fail_after_release got=%b want=%b", obs, W_FAIL);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b1;
    mode = 2'b11;
    test_reset();
    test_push();
    test_good();
    test_fail_word();
    test_back_to_back();
    test_reset_override();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/display_7seg_words.md
DISPLAY_7SEG_WORDS -- requirements
Module: display_7seg_words

Interface
REQ-001 The block SHALL have exactly one clock, and its reset SHALL be synchronous and active-high.
REQ-002 Port clk, input, 1 bit: rising-edge clock for all state.
REQ-003 Port rst, input, 1 bit: synchronous active-high reset.
REQ-004 Port mode, input, 2 bits: word select.
REQ-005 Port display_words_3, output, 7 bits: leftmost digit segment pattern.
REQ-006 Port display_words_2, output, 7 bits: second digit from left.
REQ-007 Port display_words_1, output, 7 bits: third digit from left.
REQ-008 Port display_words_0, output, 7 bits: rightmost digit.
REQ-009 Port order at instantiation SHALL be: clk, rst, mode, display_words_3, display_words_2, display_words_1, display_words_0.

Function
REQ-010 Each output SHALL use bit order {g,f,e,d,c,b,a}, so bit 6 = g and bit 0 = a.
REQ-011 Segment encoding SHALL be active-low (0 = segment lit), for common-anode displays.
REQ-012 The character generator SHALL produce these exact patterns:
- blank = 1111111
- P = 0001100
- U = 1000001
- S = 0010010
- H = 0001001
- G = 1000010
- O = 1000000
- d = 0100001
- F = 0001110
- A = 0001000
- I = 1111001
- L = 1000111
REQ-013 Any character code outside the table in REQ-012 SHALL render blank (1111111).
REQ-014 mode=00 SHALL select four blanks.
REQ-015 mode=01 SHALL select "PUSH", in digit order 3..0 = P,U,S,H.
REQ-016 mode=10 SHALL select "GOOd", in digit order 3..0 = G,O,O,d.
REQ-017 mode=11 SHALL select "FAIL", in digit order 3..0 = F,A,I,L.
REQ-018 mode SHALL be sampled on every rising clk edge.
REQ-019 All four outputs SHALL be registered and SHALL update together on the same edge, with no intermediate mixed word visible.
REQ-020 Latency SHALL be exactly one clock: a mode value present before edge N appears on the outputs after edge N.
REQ-021 If mode is held constant, the outputs SHALL be held constant; there SHALL be no scrolling or blinking.
REQ-022 When mode changes on consecutive cycles, each intermediate word SHALL appear for exactly one cycle.
REQ-023 The outputs SHALL never present X or Z after the first reset.

Reset
REQ-024 When rst=1 at a rising edge, all four outputs SHALL become 1111111 (blank), regardless of mode.
REQ-025 While rst is held high, the outputs SHALL remain blank.
REQ-026 On the first edge with rst=0, the outputs SHALL load the word for the current mode.
REQ-027 An rst asserted mid-operation SHALL override a simultaneous mode change.
REQ-028 There SHALL be no asynchronous path from rst to the outputs.

Verification
REQ-029 Scenario: rst=1 for 2 cycles with mode=11 -> all outputs = 1111111.
REQ-030 Scenario: release rst, mode=01 -> after 1 edge, outputs 3..0 = 0001100, 1000001, 0010010, 0001001.
REQ-031 Scenario: mode=10 -> after 1 edge, outputs 3..0 = 1000010, 1000000, 1000000, 0100001; before that edge the outputs still show PUSH.
REQ-032 Scenario: mode=11 -> after 1 edge, outputs 3..0 = 0001110, 0001000, 1111001, 1000111.
REQ-033 Scenario: mode=00 -> after 1 edge, all outputs = 1111111; then mode sequence 01,10,11 on successive cycles -> PUSH, GOOd, FAIL each appear for exactly one cycle.
REQ-034 Scenario: assert rst on the same edge that mode changes 01->11 -> outputs blank, and FAIL appears only on the first edge after rst deasserts.
